// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: forwarding, load-use stall, branch flush and cache-refill freeze.
// Optional performance counters (and the CNT_WIDTH parameter) exist only under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH  = 32
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addrD,
    input  logic [REG_ADDR_W-1:0] i_rs2_addrD,
    input  logic [REG_ADDR_W-1:0] i_rs1_addrE,
    input  logic [REG_ADDR_W-1:0] i_rs2_addrE,
    input  logic [REG_ADDR_W-1:0] i_rd_addrE,
    input  logic [REG_ADDR_W-1:0] i_rd_addrM,
    input  logic [REG_ADDR_W-1:0] i_rd_addrW,
    input  logic                  i_reg_weM,
    input  logic                  i_reg_weW,
    input  logic                  i_loadE,
    input  logic                  i_pc_srcE,
    input  logic                  i_icache_miss,
    input  logic                  i_dcache_miss,
    input  logic                  i_mem_ready,
    output logic                  o_stallF,
    output logic                  o_stallD,
    output logic                  o_flushD,
    output logic                  o_flushE,
    output logic                  o_stallE,
    output logic                  o_stallM,
    output logic                  o_stallW,
    output logic [1:0]            o_forwardAE,
    output logic [1:0]            o_forwardBE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0]  o_lu_stall_cnt,
    output logic [CNT_WIDTH-1:0]  o_mem_stall_cnt,
    output logic [CNT_WIDTH-1:0]  o_flush_cnt,
`endif
    output logic                  o_refill_busy
);

    typedef enum logic [1:0] {StIdle, StDRefill, StIRefill} state_e;

    state_e state_q;
    logic   busy_q;
    logic   lu;
    logic   mem_stall;

    always_comb begin
        o_forwardAE = 2'b00;
        if (i_reg_weM && (i_rs1_addrE != '0) && (i_rs1_addrE == i_rd_addrM)) begin
            o_forwardAE = 2'b10;
        end else if (i_reg_weW && (i_rs1_addrE != '0) && (i_rs1_addrE == i_rd_addrW)) begin
            o_forwardAE = 2'b01;
        end
    end

    always_comb begin
        o_forwardBE = 2'b00;
        if (i_reg_weM && (i_rs2_addrE != '0) && (i_rs2_addrE == i_rd_addrM)) begin
            o_forwardBE = 2'b10;
        end else if (i_reg_weW && (i_rs2_addrE != '0) && (i_rs2_addrE == i_rd_addrW)) begin
            o_forwardBE = 2'b01;
        end
    end

    assign lu = i_loadE && (i_rd_addrE != '0) &&
                ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

    // D-cache wins from IDLE: the M-stage access belongs to the older instruction.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_dcache_miss) begin
                        state_q <= StDRefill;
                        busy_q  <= 1'b1;
                    end else if (i_icache_miss) begin
                        state_q <= StIRefill;
                        busy_q  <= 1'b1;
                    end
                end
                StDRefill, StIRefill: begin
                    if (i_mem_ready) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A miss freezes the pipe in the cycle it appears, before the FSM has registered it.
    assign mem_stall     = busy_q || i_dcache_miss || i_icache_miss;
    assign o_refill_busy = busy_q;

    assign o_stallF = mem_stall || lu;
    assign o_stallD = mem_stall || lu;
    assign o_stallE = mem_stall;
    assign o_stallM = mem_stall;
    assign o_stallW = mem_stall;
    // Freeze beats flush; E keeps pc_srcE alive so the redirect still flushes after release.
    assign o_flushE = !mem_stall && (lu || i_pc_srcE);
    assign o_flushD = !mem_stall && i_pc_srcE;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            lu_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu && !mem_stall && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + 1'b1;
            end
            if (mem_stall && (mem_cnt_q != '1)) begin
                mem_cnt_q <= mem_cnt_q + 1'b1;
            end
            if (i_pc_srcE && !mem_stall && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign o_lu_stall_cnt  = lu_cnt_q;
    assign o_mem_stall_cnt = mem_cnt_q;
    assign o_flush_cnt     = flush_cnt_q;
`endif

endmodule
